ram_burst_master: RTL and testbench

//  Initiator for the shared 16-bit image RAM (A/WE/OE/D/Q, one-cycle read latency via

---
 rtl/ram_master_pkg.sv | 31 +++
 rtl/ram_rd_fifo.sv | 49 ++++
 rtl/ram_burst_master.sv | 154 +++++++++++++++
 tb/tb_ram_burst_master.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_master_pkg.sv
// Shared constants, FSM state type and address helper
// for the image RAM burst master.
package ram_master_pkg;

    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 16;
    localparam int LEN_W     = 10;
    localparam int MEM_DEPTH = 786432;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } rd_entry_t;

    // Step a word address, wrapping at the end of the frame RAM
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] a
    );
        if (a == ADDR_W'(MEM_DEPTH - 1))
            return '0;
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry read-data FIFO carrying {last, data}.
// Head is register-backed so outputs hold while stalled.
module ram_rd_fifo
    import ram_master_pkg::*;
(
    input  logic              CK,
    input  logic              RST_N,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        occ
);

    rd_entry_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;
    logic [1:0] cnt;
    rd_entry_t head;

    // Storage, pointers and occupancy
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{last: push_last, data: push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (cnt != 2'd0);
    assign out_data  = head.data;
    assign out_last  = out_valid & head.last;
    assign occ       = cnt;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the shared 16-bit image RAM.
// Optional sticky wrap flag: define RAM_WRAP_ERR_EN.
module ram_burst_master
    import ram_master_pkg::*;
(
    input  logic              CK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic [ADDR_W-1:0] A,
    output logic              WE,
    output logic              OE,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q
`ifdef RAM_WRAP_ERR_EN
    ,
    output logic              err_wrap
`endif
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              inflight_q, inflight_d;
    logic              infl_last_q, infl_last_d;
    logic [1:0]        fifo_occ;
    logic              pop;
    logic [2:0]        occ_sum;
    logic              issue;

    // Words committed to the FIFO, counting the one in the RAM pipe
    assign pop     = rdata_valid & rdata_ready;
    assign occ_sum = {1'b0, fifo_occ} + {2'b0, inflight_q}
                   - {2'b0, pop};
    assign issue   = (state_q == READ) && (occ_sum < 3'd2);
    assign busy    = (state_q != IDLE);

    // State, address and burst bookkeeping registers
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            a_q         <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            a_q         <= a_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
        end
    end

    // Next-state and RAM/stream control
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        a_d         = a_q;
        inflight_d  = 1'b0;
        infl_last_d = infl_last_q;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        WE          = 1'b0;
        OE          = 1'b0;
        A           = a_q;
        D           = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cur_addr_d  = req_addr;
                    remaining_d = req_len;
                    state_d     = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    WE          = 1'b1;
                    A           = cur_addr_q;
                    D           = wdata;
                    a_d         = cur_addr_q;
                    cur_addr_d  = next_addr(cur_addr_q);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == '0)
                        state_d = IDLE;
                end
            end
            READ: begin
                OE = 1'b1;
                if (issue) begin
                    A           = cur_addr_q;
                    a_d         = cur_addr_q;
                    cur_addr_d  = next_addr(cur_addr_q);
                    remaining_d = remaining_q - LEN_W'(1);
                    inflight_d  = 1'b1;
                    infl_last_d = (remaining_q == '0);
                    if (remaining_q == '0)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                OE = inflight_q;
                if (!inflight_q && fifo_occ == 2'd0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    ram_rd_fifo u_fifo (
        .CK        (CK),
        .RST_N     (RST_N),
        .push      (inflight_q),
        .push_data (Q),
        .push_last (infl_last_q),
        .pop       (pop),
        .out_valid (rdata_valid),
        .out_data  (rdata),
        .out_last  (rdata_last),
        .occ       (fifo_occ)
    );

`ifdef RAM_WRAP_ERR_EN
    logic wrap_hit;
    assign wrap_hit = (WE | issue)
                    & (cur_addr_q == ADDR_W'(MEM_DEPTH - 1));

    // Sticky flag for any burst stepping past the last RAM word
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N)
            err_wrap <= 1'b0;
        else if (wrap_hit)
            err_wrap <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural
// one-cycle-latency RAM; bursts come from a vector table.
module tb_ram_burst_master;

    logic        CK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [19:0] req_addr;
    logic [9:0]  req_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [15:0] wdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic [15:0] rdata;
    logic        rdata_last;
    logic        busy;
    logic [19:0] A;
    logic        WE;
    logic        OE;
    logic [15:0] D;
    logic [15:0] Q;
`ifdef RAM_WRAP_ERR_EN
    logic        err_wrap;
`endif

    int checks;
    int failures;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [9:0]  len;
        logic [15:0] base;
        logic [15:0] step;
        logic [7:0]  pat;
        logic [19:0] last_a;
    } vec_t;

    vec_t tbl [8];

    logic [15:0] mem [0:4095];

    ram_burst_master dut (
        .CK          (CK),
        .RST_N       (RST_N),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .busy        (busy),
        .A           (A),
        .WE          (WE),
        .OE          (OE),
        .D           (D),
        .Q           (Q)
`ifdef RAM_WRAP_ERR_EN
        ,
        .err_wrap    (err_wrap)
`endif
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // RAM: registered address, data on Q the cycle after
    always @(posedge CK) begin
        if (WE)
            mem[A[11:0]] <= D;
        if (OE)
            Q <= mem[A[11:0]];
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     nm, act, exp);
        end
    endtask

    task automatic run_write(input vec_t v);
        int i;
        int j;
        logic vld;
        logic [19:0] ea;
        @(negedge CK);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = v.addr;
        req_len   = v.len;
        #1;
        chk("wr_req_ready", 32'(req_ready), 32'd1);
        @(negedge CK);
        req_valid = 1'b0;
        i  = 0;
        j  = 0;
        ea = v.addr;
        while (i <= int'(v.len) && j < 100) begin
            vld         = v.pat[j % 8];
            wdata_valid = vld;
            wdata       = v.base + 16'(i) * v.step;
            #1;
            chk("wr_we", 32'(WE), 32'(vld));
            chk("wr_oe", 32'(OE), 32'd0);
            chk("wr_wdata_ready", 32'(wdata_ready), 32'd1);
            if (vld) begin
                chk("wr_a", 32'(A), 32'(ea));
                chk("wr_d", 32'(D), 32'(wdata));
                if (i == int'(v.len))
                    chk("wr_last_a", 32'(A), 32'(v.last_a));
                ea = (ea == 20'd786431) ? 20'd0 : ea + 20'd1;
                i++;
            end
            @(negedge CK);
            j++;
        end
        wdata_valid = 1'b0;
        chk("wr_words", 32'(i), 32'(v.len) + 32'd1);
        #1;
        chk("wr_done_busy", 32'(busy), 32'd0);
        chk("wr_done_ready", 32'(wdata_ready), 32'd0);
    endtask

    task automatic run_read(input vec_t v);
        int k;
        int cyc;
        int first;
        int last_cyc;
        int n;
        logic        held_v;
        logic [16:0] held;
        logic [15:0] ed;
        @(negedge CK);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_addr    = v.addr;
        req_len     = v.len;
        rdata_ready = 1'b0;
        #1;
        chk("rd_req_ready", 32'(req_ready), 32'd1);
        @(negedge CK);
        req_valid = 1'b0;
        k        = 0;
        cyc      = 1;
        first    = -1;
        last_cyc = -1;
        held_v   = 1'b0;
        held     = '0;
        while (k <= int'(v.len) && cyc < 200) begin
            rdata_ready = v.pat[cyc % 8];
            #1;
            chk("rd_we", 32'(WE), 32'd0);
            if (held_v)
                chk("rd_stable",
                    32'({rdata_valid, rdata_last, rdata}),
                    32'({1'b1, held}));
            if (rdata_valid) begin
                if (first < 0)
                    first = cyc;
                if (rdata_ready) begin
                    ed = v.base + 16'(k) * v.step;
                    chk("rd_data", 32'(rdata), 32'(ed));
                    chk("rd_last", 32'(rdata_last),
                        32'(k == int'(v.len)));
                    last_cyc = cyc;
                    held_v   = 1'b0;
                    k++;
                end else begin
                    held_v = 1'b1;
                    held   = {rdata_last, rdata};
                end
            end else begin
                held_v = 1'b0;
            end
            @(negedge CK);
            cyc++;
        end
        rdata_ready = 1'b0;
        chk("rd_words", 32'(k), 32'(v.len) + 32'd1);
        if (v.pat == 8'hFF) begin
            chk("rd_latency", 32'(first), 32'd3);
            chk("rd_span", 32'(last_cyc - first), 32'(v.len));
        end
        n = 0;
        while (busy && n < 20) begin
            @(negedge CK);
            n++;
        end
        chk("rd_idle", 32'(busy), 32'd0);
        chk("rd_empty", 32'(rdata_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;
        vec_t rv;

        checks   = 0;
        failures = 0;
        for (int i = 0; i < 4096; i++)
            mem[i] = '0;
        Q = '0;

        tbl[0] = '{1'b1, 20'h00010, 10'd3, 16'h1111,
                   16'h1111, 8'hFF, 20'h00013};
        tbl[1] = '{1'b0, 20'h00010, 10'd3, 16'h1111,
                   16'h1111, 8'hFF, 20'h00000};
        tbl[2] = '{1'b1, 20'h00100, 10'd7, 16'hA000,
                   16'h0001, 8'hFF, 20'h00107};
        tbl[3] = '{1'b0, 20'h00100, 10'd7, 16'hA000,
                   16'h0001, 8'h55, 20'h00000};
        tbl[4] = '{1'b1, 20'd786431, 10'd1, 16'hBEEF,
                   16'h0001, 8'hFF, 20'h00000};
        tbl[5] = '{1'b1, 20'h00200, 10'd1, 16'h5555,
                   16'h1111, 8'h09, 20'h00201};
        tbl[6] = '{1'b0, 20'd786431, 10'd1, 16'hBEEF,
                   16'h0001, 8'hFF, 20'h00000};
        tbl[7] = '{1'b0, 20'h00200, 10'd1, 16'h5555,
                   16'h1111, 8'hFF, 20'h00000};

        RST_N       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b0;

        @(negedge CK);
        @(negedge CK);
        #1;
        chk("rst_a", 32'(A), 32'd0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_oe", 32'(OE), 32'd0);
        chk("rst_d", 32'(D), 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_rlast", 32'(rdata_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
`ifdef RAM_WRAP_ERR_EN
        chk("rst_err_wrap", 32'(err_wrap), 32'd0);
`endif
        @(negedge CK);
        RST_N = 1'b1;

        for (int r = 0; r < 8; r++) begin
            if (tbl[r].wr)
                run_write(tbl[r]);
            else
                run_read(tbl[r]);
`ifdef RAM_WRAP_ERR_EN
            chk("err_wrap", 32'(err_wrap), 32'(r >= 4));
`endif
        end

        // Reset while the third word of an 8-word read is due
        @(negedge CK);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_addr    = 20'h00100;
        req_len     = 10'd7;
        rdata_ready = 1'b1;
        @(negedge CK);
        req_valid = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < 2 && cyc < 50) begin
            #1;
            if (rdata_valid) begin
                chk("rst_pre_data", 32'(rdata),
                    32'(16'hA000 + 16'(k)));
                k++;
            end
            @(negedge CK);
            cyc++;
        end
        chk("rst_pre_words", 32'(k), 32'd2);
        RST_N = 1'b0;
        #1;
        chk("abort_oe", 32'(OE), 32'd0);
        chk("abort_we", 32'(WE), 32'd0);
        chk("abort_rvalid", 32'(rdata_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_a", 32'(A), 32'd0);
        rdata_ready = 1'b0;
        @(negedge CK);
        RST_N = 1'b1;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rvalid2", 32'(rdata_valid), 32'd0);
`ifdef RAM_WRAP_ERR_EN
        chk("abort_err_wrap", 32'(err_wrap), 32'd0);
`endif

        rv     = tbl[3];
        rv.pat = 8'hFF;
        run_read(rv);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
